// File: rtl/decoder_3l_pkg.sv
// ---------------------------------------------------------------------------
// decoder_3l_pkg
// Shared types and helpers for the multi-leg three-level switch-pattern
// decoder: topology codes, level codes, leg FSM state encoding, the
// (topology, level) -> gate pattern lookup and the "must pass through zero"
// predicate.
// ---------------------------------------------------------------------------
package decoder_3l_pkg;

  typedef enum logic [1:0] {
    TOPO_OFF  = 2'd0,
    TOPO_NPC  = 2'd1,
    TOPO_NPP  = 2'd2,
    TOPO_ANPC = 2'd3
  } topo_t;

  // Code 3 means "hold current level" on the request bus. Internally the
  // same code marks a leg that is (or is heading to) fully off, because a
  // hold request is never latched as a target.
  typedef enum logic [1:0] {
    LVL_N   = 2'd0,
    LVL_Z   = 2'd1,
    LVL_P   = 2'd2,
    LVL_OFF = 2'd3
  } lvl_t;

  localparam logic [1:0] REQ_HOLD = 2'd3;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_HOLD = 2'd1,
    ST_DEAD = 2'd2,
    ST_MID  = 2'd3
  } leg_state_t;

  // Gate pattern {s1,s2,s3,s4,s5,s6} for a level under a topology.
  // NPC and NPP share the same patterns; only ANPC drives s5/s6.
  function automatic logic [5:0] pattern(topo_t topo, lvl_t lvl);
    logic [5:0] p;
    p = 6'b000000;
    if (topo == TOPO_ANPC) begin
      case (lvl)
        LVL_P:   p = 6'b110001;
        LVL_Z:   p = 6'b010010;
        LVL_N:   p = 6'b001110;
        default: p = 6'b000000;
      endcase
    end else if (topo != TOPO_OFF) begin
      case (lvl)
        LVL_P:   p = 6'b110000;
        LVL_Z:   p = 6'b011000;
        LVL_N:   p = 6'b001100;
        default: p = 6'b000000;
      endcase
    end
    return p;
  endfunction

  // A direct P<->N commutation is only legal on a T-type (NPP) leg; the
  // NPC and ANPC legs have to dwell at zero in between.
  function automatic logic needs_mid(topo_t topo, lvl_t from, lvl_t to);
    return ((topo == TOPO_NPC) || (topo == TOPO_ANPC)) &&
           (((from == LVL_P) && (to == LVL_N)) ||
            ((from == LVL_N) && (to == LVL_P)));
  endfunction

endpackage

// File: rtl/decoder_3l_multileg_if.sv
// ---------------------------------------------------------------------------
// decoder_3l_multileg_if
// Bundle between the modulator and the decoder.
//   ce      clock enable for counters and FSMs
//   topo    requested topology (0=OFF 1=NPC 2=NPP 3=ANPC)
//   t_dead  dead time in ce-cycles (0 behaves as 1)
//   v_lev   per-leg level request, leg k at [2k+1:2k]
//   trip    hardware fault request
//   s_out   gate signals, leg k at [6k+5:6k] = {s1..s6}
//   busy    per-leg transition flag
//   fault   sticky trip flag
// master = modulator side, slave = decoder side.
// ---------------------------------------------------------------------------
interface decoder_3l_multileg_if #(
  parameter int N_LEGS = 3,
  parameter int TW     = 10
);
  logic                  ce;
  logic [1:0]            topo;
  logic [TW-1:0]         t_dead;
  logic [2*N_LEGS-1:0]   v_lev;
  logic                  trip;
  logic [6*N_LEGS-1:0]   s_out;
  logic [N_LEGS-1:0]     busy;
  logic                  fault;

  modport master (
    output ce, topo, t_dead, v_lev, trip,
    input  s_out, busy, fault
  );

  modport slave (
    input  ce, topo, t_dead, v_lev, trip,
    output s_out, busy, fault
  );
endinterface

// File: rtl/leg_fsm_3l.sv
// ---------------------------------------------------------------------------
// leg_fsm_3l
// One phase leg: OFF / HOLD / DEAD / MID sequencer with a dead-time counter
// and registered gate outputs.
//   clk, rst  clock, synchronous active-high reset
//   ce        advance enable for FSM and counter
//   kill      trip or sticky fault: force OFF on this edge, ignores ce
//   shutdown  topology change pending: leave HOLD toward OFF
//   topo      latched topology used for patterns
//   term      dead-time terminal count (already max(t_dead,1)-1)
//   req       level request for this leg
//   s_out     registered gate pattern {s1..s6}
//   busy      registered "in DEAD or MID"
//   is_off    leg currently in OFF (unregistered state decode)
// ---------------------------------------------------------------------------
module leg_fsm_3l
  import decoder_3l_pkg::*;
#(
  parameter int TW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          kill,
  input  logic          shutdown,
  input  topo_t         topo,
  input  logic [TW-1:0] term,
  input  logic [1:0]    req,
  output logic [5:0]    s_out,
  output logic          busy,
  output logic          is_off
);

  leg_state_t    state_q, state_d;
  lvl_t          cur_q, cur_d;     // level the switches are leaving / holding
  lvl_t          tgt_q, tgt_d;     // level the current DEAD is heading to
  lvl_t          fin_q, fin_d;     // final level behind an intermediate Z
  logic          pend_q, pend_d;   // fin_q is valid
  logic [TW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] term_q, term_d;   // terminal count frozen at DEAD/MID entry
  logic [5:0]    s_q, s_d;
  logic          busy_q, busy_d;

  lvl_t req_lvl;
  assign req_lvl = lvl_t'(req);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: every flop is updated with <= so all state moves together on the
    // edge regardless of statement order.
    if (rst) begin
      state_q <= ST_OFF;
      cur_q   <= LVL_OFF;
      tgt_q   <= LVL_OFF;
      fin_q   <= LVL_OFF;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      term_q  <= '0;
      s_q     <= 6'b000000;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      fin_q   <= fin_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      term_q  <= term_d;
      s_q     <= s_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every signal starts from its held value so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    fin_d   = fin_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    term_d  = term_q;

    if (kill) begin
      state_d = ST_OFF;
      cur_d   = LVL_OFF;
      tgt_d   = LVL_OFF;
      pend_d  = 1'b0;
      cnt_d   = '0;
    end else if (ce) begin
      unique case (state_q)
        ST_OFF: begin
          if ((topo != TOPO_OFF) && !shutdown && (req != REQ_HOLD)) begin
            state_d = ST_DEAD;
            tgt_d   = req_lvl;
            pend_d  = 1'b0;
            cnt_d   = '0;
            term_d  = term;
          end
        end
        ST_HOLD: begin
          if (shutdown) begin
            state_d = ST_DEAD;
            tgt_d   = LVL_OFF;
            pend_d  = 1'b0;
            cnt_d   = '0;
            term_d  = term;
          end else if ((req != REQ_HOLD) && (req_lvl != cur_q)) begin
            state_d = ST_DEAD;
            cnt_d   = '0;
            term_d  = term;
            if (needs_mid(topo, cur_q, req_lvl)) begin
              tgt_d  = LVL_Z;
              fin_d  = req_lvl;
              pend_d = 1'b1;
            end else begin
              tgt_d  = req_lvl;
              pend_d = 1'b0;
            end
          end
        end
        ST_DEAD: begin
          if (cnt_q == term_q) begin
            cur_d = tgt_q;
            cnt_d = '0;
            if (tgt_q == LVL_OFF) begin
              state_d = ST_OFF;
            end else if (pend_q) begin
              state_d = ST_MID;
              term_d  = term;
            end else begin
              state_d = ST_HOLD;
            end
          end else begin
            cnt_d = cnt_q + TW'(1);
          end
        end
        ST_MID: begin
          if (cnt_q == term_q) begin
            state_d = ST_DEAD;
            tgt_d   = fin_q;
            pend_d  = 1'b0;
            cnt_d   = '0;
            term_d  = term;
          end else begin
            cnt_d = cnt_q + TW'(1);
          end
        end
      endcase
    end
  end

  // Output logic. In DEAD only switches common to both patterns stay on:
  // outgoing ones drop at once, incoming ones wait for HOLD.
  always_comb begin
    s_d    = 6'b000000;
    busy_d = 1'b0;
    if (!kill) begin
      case (state_q)
        ST_HOLD: s_d = pattern(topo, cur_q);
        ST_DEAD: begin
          s_d    = pattern(topo, cur_q) & pattern(topo, tgt_q);
          busy_d = 1'b1;
        end
        ST_MID: begin
          s_d    = pattern(topo, cur_q);
          busy_d = 1'b1;
        end
        default: s_d = 6'b000000;
      endcase
    end
  end

  assign s_out  = s_q;
  assign busy   = busy_q;
  assign is_off = (state_q == ST_OFF);

endmodule

// File: rtl/decoder_3l_multileg.sv
// ---------------------------------------------------------------------------
// decoder_3l_multileg
// Multi-leg three-level gate decoder (NPC / NPP / ANPC) with dead-time
// sequencing. Latches the topology and sequences topology changes through
// OFF, keeps the sticky trip flag, and instantiates one leg_fsm_3l per leg.
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  decoder_3l_multileg_if.slave (ce, topo, t_dead, v_lev, trip in;
//        s_out, busy, fault out)
// ---------------------------------------------------------------------------
module decoder_3l_multileg
  import decoder_3l_pkg::*;
#(
  parameter int N_LEGS = 3,
  parameter int TW     = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  decoder_3l_multileg_if.slave  bus
);

  topo_t topo_q, topo_d;
  logic  fault_q, fault_d;

  logic                kill;
  logic                topo_chg;
  logic [TW-1:0]       term;
  logic [N_LEGS-1:0]   leg_off;
  logic [6*N_LEGS-1:0] s_cat;
  logic [N_LEGS-1:0]   busy_cat;

  assign kill     = bus.trip | fault_q;
  assign topo_chg = (topo_t'(bus.topo) != topo_q);
  assign term     = (bus.t_dead == '0) ? '0 : (bus.t_dead - TW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      topo_q  <= TOPO_OFF;
      fault_q <= 1'b0;
    end else begin
      topo_q  <= topo_d;
      fault_q <= fault_d;
    end
  end

  // A new topology is only adopted once every leg has drained to OFF, so
  // no leg ever mixes patterns from two topologies.
  always_comb begin
    topo_d  = topo_q;
    fault_d = fault_q | bus.trip;
    if (bus.ce && topo_chg && (&leg_off)) begin
      topo_d = topo_t'(bus.topo);
    end
  end

  for (genvar k = 0; k < N_LEGS; k++) begin : g_leg
    leg_fsm_3l #(.TW(TW)) u_leg (
      .clk      (clk),
      .rst      (rst),
      .ce       (bus.ce),
      .kill     (kill),
      .shutdown (topo_chg),
      .topo     (topo_q),
      .term     (term),
      .req      (bus.v_lev[2*k +: 2]),
      .s_out    (s_cat[6*k +: 6]),
      .busy     (busy_cat[k]),
      .is_off   (leg_off[k])
    );
  end

  assign bus.s_out = s_cat;
  assign bus.busy  = busy_cat;
  assign bus.fault = fault_q;

endmodule

// File: tb/tb_decoder_3l_multileg.sv
// ---------------------------------------------------------------------------
// tb_decoder_3l_multileg
// Directed self-checking bench for decoder_3l_multileg with three legs.
// Inputs change and outputs are sampled 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_decoder_3l_multileg;

  localparam int N_LEGS = 3;
  localparam int TW     = 10;

  localparam logic [5:0] NPC_P  = 6'b110000;
  localparam logic [5:0] NPC_Z  = 6'b011000;
  localparam logic [5:0] NPC_N  = 6'b001100;
  localparam logic [5:0] ANPC_P = 6'b110001;
  localparam logic [5:0] ANPC_N = 6'b001110;

  localparam logic [1:0] LN = 2'd0;
  localparam logic [1:0] LZ = 2'd1;
  localparam logic [1:0] LP = 2'd2;
  localparam logic [1:0] LH = 2'd3;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  decoder_3l_multileg_if #(.N_LEGS(N_LEGS), .TW(TW)) bus ();

  decoder_3l_multileg #(.N_LEGS(N_LEGS), .TW(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sout(input string tag, input logic [6*N_LEGS-1:0] exp);
    int n;
    n = 0;
    while ((bus.s_out !== exp) && (n < 200)) begin
      tick();
      n++;
    end
    check(tag, 32'(bus.s_out), 32'(exp));
  endtask

  logic [5:0] anpc_seq [7];

  initial begin
    n_checks = 0;
    n_errors = 0;
    anpc_seq = '{6'b010000, 6'b010000, 6'b010010, 6'b010010,
                 6'b000010, 6'b000010, ANPC_N};

    rst        = 1'b1;
    bus.ce     = 1'b1;
    bus.topo   = 2'd0;
    bus.t_dead = 10'd4;
    bus.v_lev  = {LH, LH, LH};
    bus.trip   = 1'b0;
    tick();
    tick();
    check("rst_sout",  32'(bus.s_out), 32'd0);
    check("rst_busy",  32'(bus.busy),  32'd0);
    check("rst_fault", 32'(bus.fault), 32'd0);
    rst = 1'b0;

    // Requests with topology OFF leave everything off.
    bus.v_lev = {LP, LP, LZ};
    repeat (4) tick();
    check("topo_off_idle", 32'(bus.s_out), 32'd0);

    // NPC, t_dead=4, leg0 Z->P.
    bus.topo = 2'd1;
    wait_sout("npc_up", {NPC_P, NPC_P, NPC_Z});
    bus.v_lev = {LP, LP, LP};
    tick();
    check("zp_pre", 32'(bus.s_out[5:0]), 32'(NPC_Z));
    check("zp_pre_busy", 32'(bus.busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("zp_dead", 32'(bus.s_out[5:0]), 32'b010000);
      check("zp_dead_busy", 32'(bus.busy), 32'b001);
    end
    tick();
    check("zp_done", 32'(bus.s_out[5:0]), 32'(NPC_P));
    check("zp_done_busy", 32'(bus.busy), 32'd0);

    // NPP, t_dead=3, leg2 P->N directly.
    bus.topo   = 2'd2;
    bus.t_dead = 10'd3;
    wait_sout("npp_drain", '0);
    wait_sout("npp_up", {NPC_P, NPC_P, NPC_P});
    bus.v_lev = {LN, LP, LP};
    tick();
    check("npp_pre", 32'(bus.s_out[17:12]), 32'(NPC_P));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("npp_dead", 32'(bus.s_out[17:12]), 32'b000000);
      check("npp_dead_busy", 32'(bus.busy), 32'b100);
    end
    tick();
    check("npp_done", 32'(bus.s_out[17:12]), 32'(NPC_N));
    check("npp_done_busy", 32'(bus.busy), 32'd0);

    // ANPC, t_dead=2, leg1 P->N through Z.
    bus.topo   = 2'd3;
    bus.t_dead = 10'd2;
    bus.v_lev  = {LP, LP, LP};
    wait_sout("anpc_drain", '0);
    wait_sout("anpc_up", {ANPC_P, ANPC_P, ANPC_P});
    bus.v_lev = {LP, LN, LP};
    tick();
    check("anpc_pre", 32'(bus.s_out[11:6]), 32'(ANPC_P));
    for (int i = 0; i < 7; i++) begin
      tick();
      check("anpc_seq", 32'(bus.s_out[11:6]), 32'(anpc_seq[i]));
      check("anpc_busy", 32'(bus.busy), (i < 6) ? 32'b010 : 32'b000);
    end

    // Topology change ANPC->NPC while all legs hold P.
    bus.v_lev = {LP, LP, LP};
    wait_sout("anpc_allp", {ANPC_P, ANPC_P, ANPC_P});
    bus.v_lev = {LH, LH, LH};
    bus.topo  = 2'd1;
    tick();
    check("chg_pre", 32'(bus.s_out), 32'({ANPC_P, ANPC_P, ANPC_P}));
    for (int i = 0; i < 2; i++) begin
      tick();
      check("chg_dead", 32'(bus.s_out), 32'd0);
      check("chg_dead_busy", 32'(bus.busy), 32'b111);
    end
    tick();
    check("chg_off", 32'(bus.s_out), 32'd0);
    check("chg_off_busy", 32'(bus.busy), 32'd0);
    bus.v_lev = {LP, LP, LP};
    wait_sout("chg_npc_up", {NPC_P, NPC_P, NPC_P});

    // ce one cycle in three, t_dead=2, leg0 P->Z; a request during DEAD is ignored.
    bus.v_lev = {LP, LP, LZ};
    bus.ce    = 1'b1;
    tick();
    check("ce_pre", 32'(bus.s_out[5:0]), 32'(NPC_P));
    bus.v_lev = {LP, LP, LN};
    for (int i = 1; i <= 6; i++) begin
      bus.ce = (i % 3 == 0);
      tick();
      check("ce_dead", 32'(bus.s_out[5:0]), 32'b010000);
      check("ce_dead_busy", 32'(bus.busy), 32'b001);
    end
    bus.ce = 1'b0;
    tick();
    check("ce_done", 32'(bus.s_out[5:0]), 32'(NPC_Z));
    check("ce_done_busy", 32'(bus.busy), 32'd0);

    // t_dead=0 behaves as one cycle: leg0 Z->P.
    bus.ce     = 1'b1;
    bus.t_dead = 10'd0;
    bus.v_lev  = {LP, LP, LP};
    tick();
    check("td0_pre", 32'(bus.s_out[5:0]), 32'(NPC_Z));
    tick();
    check("td0_dead", 32'(bus.s_out[5:0]), 32'b010000);
    tick();
    check("td0_done", 32'(bus.s_out[5:0]), 32'(NPC_P));

    // Trip in the middle of DEAD on all legs.
    bus.t_dead = 10'd4;
    bus.v_lev  = {LZ, LZ, LZ};
    tick();
    tick();
    check("trip_pre", 32'(bus.s_out), 32'({6'b010000, 6'b010000, 6'b010000}));
    bus.trip = 1'b1;
    tick();
    check("trip_sout",  32'(bus.s_out), 32'd0);
    check("trip_fault", 32'(bus.fault), 32'd1);
    check("trip_busy",  32'(bus.busy),  32'd0);
    bus.trip  = 1'b0;
    bus.v_lev = {LP, LP, LP};
    repeat (8) tick();
    check("fault_hold_sout",  32'(bus.s_out), 32'd0);
    check("fault_hold_fault", 32'(bus.fault), 32'd1);
    rst = 1'b1;
    tick();
    check("rst2_sout",  32'(bus.s_out), 32'd0);
    check("rst2_fault", 32'(bus.fault), 32'd0);
    check("rst2_busy",  32'(bus.busy),  32'd0);
    rst = 1'b0;
    wait_sout("post_rst_up", {NPC_P, NPC_P, NPC_P});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
